// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor with signed/unsigned set-less-than.
// The carry chain advances one CHUNK-bit slice per stage behind a valid/ready handshake.
module pipelined_add_sub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             cout
);

    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned SW     = CHUNK + 1;

    logic             advance;
    logic             sub;
    logic [WIDTH-1:0] bx;

    // The whole pipe moves together; a stalled output freezes every stage.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign sub      = (op != 2'b00);
    assign bx       = sub ? ~b : b;

    // Feed into the output stage: the top slice still to add plus finished low bits.
    logic             fin_vld;
    logic [1:0]       fin_op;
    logic [WIDTH-1:0] fin_low;
    logic [CHUNK-1:0] fin_a;
    logic [CHUNK-1:0] fin_b;
    logic             fin_cin;

    if (STAGES == 1) begin : g_single
        assign fin_vld = in_valid;
        assign fin_op  = op;
        assign fin_low = '0;
        assign fin_a   = a;
        assign fin_b   = bx;
        assign fin_cin = sub;
    end else begin : g_pipe
        for (genvar k = 0; k < STAGES - 1; k++) begin : stg
            localparam int unsigned DONE = (k + 1) * CHUNK;
            localparam int unsigned REM  = WIDTH - DONE;

            logic             vld;
            logic [1:0]       opq;
            logic [DONE-1:0]  sum;
            logic             cy;
            logic [REM-1:0]   a_rem;
            logic [REM-1:0]   b_rem;

            logic             nxt_vld;
            logic [1:0]       nxt_op;
            logic [CHUNK-1:0] sa;
            logic [CHUNK-1:0] sb;
            logic             cin;
            logic [REM-1:0]   nxt_a;
            logic [REM-1:0]   nxt_b;
            logic [DONE-1:0]  nxt_sum;
            logic [SW-1:0]    add;

            if (k == 0) begin : g_first
                assign nxt_vld = in_valid;
                assign nxt_op  = op;
                assign sa      = a[CHUNK-1:0];
                assign sb      = bx[CHUNK-1:0];
                assign cin     = sub;
                assign nxt_a   = a[WIDTH-1:CHUNK];
                assign nxt_b   = bx[WIDTH-1:CHUNK];
                assign nxt_sum = add[CHUNK-1:0];
            end else begin : g_next
                // Unconsumed operand slices are kept right-aligned and shifted down each stage.
                assign nxt_vld = stg[k-1].vld;
                assign nxt_op  = stg[k-1].opq;
                assign sa      = stg[k-1].a_rem[CHUNK-1:0];
                assign sb      = stg[k-1].b_rem[CHUNK-1:0];
                assign cin     = stg[k-1].cy;
                assign nxt_a   = stg[k-1].a_rem[REM+CHUNK-1:CHUNK];
                assign nxt_b   = stg[k-1].b_rem[REM+CHUNK-1:CHUNK];
                assign nxt_sum = {add[CHUNK-1:0], stg[k-1].sum};
            end

            assign add = SW'(sa) + SW'(sb) + SW'(cin);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld   <= 1'b0;
                    opq   <= 2'b00;
                    sum   <= '0;
                    cy    <= 1'b0;
                    a_rem <= '0;
                    b_rem <= '0;
                end else if (advance) begin
                    vld   <= nxt_vld;
                    opq   <= nxt_op;
                    sum   <= nxt_sum;
                    cy    <= add[CHUNK];
                    a_rem <= nxt_a;
                    b_rem <= nxt_b;
                end
            end
        end

        assign fin_vld = stg[STAGES-2].vld;
        assign fin_op  = stg[STAGES-2].opq;
        assign fin_low = WIDTH'(stg[STAGES-2].sum);
        assign fin_a   = stg[STAGES-2].a_rem;
        assign fin_b   = stg[STAGES-2].b_rem;
        assign fin_cin = stg[STAGES-2].cy;
    end

    logic [SW-1:0]    fin_add;
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] res;
    logic             c_out;
    logic             ovf;
    logic             lt;

    // Top slice, flags and compare; carry into the MSB is recovered as a^b^sum at that bit.
    always_comb begin
        fin_add = SW'(fin_a) + SW'(fin_b) + SW'(fin_cin);
        raw_sum = fin_low | (WIDTH'(fin_add[CHUNK-1:0]) << (WIDTH - CHUNK));
        c_out   = fin_add[CHUNK];
        ovf     = fin_a[CHUNK-1] ^ fin_b[CHUNK-1] ^ fin_add[CHUNK-1] ^ c_out;
        lt      = fin_op[0] ? ~c_out : (raw_sum[WIDTH-1] ^ ovf);
        res     = fin_op[1] ? WIDTH'(lt) : raw_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            cout      <= 1'b0;
        end else if (advance) begin
            out_valid <= fin_vld;
            result    <= res;
            zero      <= ~|raw_sum;
            overflow  <= ovf;
            cout      <= c_out;
        end
    end

endmodule
